// File: rtl/fastreadout_pkg.sv
// Shared types and helpers for the fast-readout scan sequencer.
package fastreadout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    XFER,
    HDR
  } state_t;

  // First header byte of a frame when the header feature is built in.
  localparam logic [7:0] HDR_SYNC = 8'hA5;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Bits needed to hold the value n.
  function automatic int unsigned val_w(input int unsigned n);
    return idx_w(n + 1);
  endfunction

endpackage

// File: rtl/fastreadout_addr_counter.sv
// Row/column address counters with end-of-row/column flags and one-hot row decode.
module fastreadout_addr_counter
  import fastreadout_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    col_inc,
  input  logic                    row_inc,
  output logic [idx_w(COLS)-1:0]  col,
  output logic                    last_col,
  output logic                    last_row,
  output logic [ROWS-1:0]         row_onehot
);

  localparam int unsigned ROW_W = idx_w(ROWS);
  localparam int unsigned COL_W = idx_w(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row;

  assign last_row   = (row == ROW_LAST);
  assign last_col   = (col == COL_LAST);
  assign row_onehot = ROWS'(1) << row;

  // Counters saturate at their last index; only clr returns them to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (row_inc && !last_row) begin
      row <= row + ROW_W'(1);
      col <= '0;
    end else if (col_inc && !last_col) begin
      col <= col + COL_W'(1);
    end
  end

endmodule

// File: rtl/fastreadout_scan_ctrl.sv
// Fast-readout scan sequencer: row select, settle, per-column sample and
// valid/ready byte output. Optional frame header enabled by FASTREADOUT_HEADER_EN.
module fastreadout_scan_ctrl
  import fastreadout_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   start,
  input  logic                   cont_mode,
  input  logic                   abort,
  output logic [ROWS-1:0]        row_sel,
  output logic [idx_w(COLS)-1:0] col_addr,
  output logic                   sample_en,
  input  logic [DATA_W-1:0]      pix_in,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned SET_W = idx_w(SETTLE_CYC);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  state_t            state, state_d;
  logic [SET_W-1:0]  settle_cnt, settle_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              clr, col_inc, row_inc;
  logic              last_col, last_row;
  logic [ROWS-1:0]   row_onehot;
  logic              hs;
`ifdef FASTREADOUT_HEADER_EN
  logic              hdr_idx, hdr_idx_d;
  logic [7:0]        frame_cnt, frame_cnt_d;
`endif

  fastreadout_addr_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .col_inc    (col_inc),
    .row_inc    (row_inc),
    .col        (col_addr),
    .last_col   (last_col),
    .last_row   (last_row),
    .row_onehot (row_onehot)
  );

  assign busy    = (state != IDLE);
  assign row_sel = busy ? row_onehot : '0;
  assign hs      = out_valid && out_ready;

  // State, settle counter and output byte registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
`ifdef FASTREADOUT_HEADER_EN
      hdr_idx    <= 1'b0;
      frame_cnt  <= '0;
`endif
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
`ifdef FASTREADOUT_HEADER_EN
      hdr_idx    <= hdr_idx_d;
      frame_cnt  <= frame_cnt_d;
`endif
    end
  end

  // Next-state and strobes; abort outranks everything, ena=0 freezes the rest.
  always_comb begin
    state_d     = state;
    settle_d    = settle_cnt;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    clr         = 1'b0;
    col_inc     = 1'b0;
    row_inc     = 1'b0;
    sample_en   = 1'b0;
    frame_done  = 1'b0;
`ifdef FASTREADOUT_HEADER_EN
    hdr_idx_d   = hdr_idx;
    frame_cnt_d = frame_cnt;
`endif
    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      settle_d    = '0;
      clr         = 1'b1;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            clr      = 1'b1;
            settle_d = '0;
`ifdef FASTREADOUT_HEADER_EN
            hdr_idx_d = 1'b0;
            state_d   = HDR;
`else
            state_d   = SETTLE;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
          else settle_d = settle_cnt + SET_W'(1);
        end
        SAMPLE: begin
          sample_en   = 1'b1;
          out_data_d  = pix_in;
          out_valid_d = 1'b1;
          state_d     = XFER;
        end
        XFER: begin
          if (hs) begin
            out_valid_d = 1'b0;
            if (!last_col) begin
              col_inc = 1'b1;
              state_d = SAMPLE;
            end else if (!last_row) begin
              row_inc  = 1'b1;
              settle_d = '0;
              state_d  = SETTLE;
            end else begin
              frame_done = 1'b1;
              clr        = 1'b1;
              settle_d   = '0;
`ifdef FASTREADOUT_HEADER_EN
              frame_cnt_d = frame_cnt + 8'd1;
              hdr_idx_d   = 1'b0;
              state_d     = cont_mode ? HDR : IDLE;
`else
              state_d     = cont_mode ? SETTLE : IDLE;
`endif
            end
          end
        end
`ifdef FASTREADOUT_HEADER_EN
        // Header bytes use the same load / handshake / drop rhythm as pixels.
        HDR: begin
          if (!out_valid) begin
            out_data_d  = hdr_idx ? DATA_W'(frame_cnt) : DATA_W'(HDR_SYNC);
            out_valid_d = 1'b1;
          end else if (hs) begin
            out_valid_d = 1'b0;
            if (hdr_idx) begin
              settle_d = '0;
              state_d  = SETTLE;
            end else begin
              hdr_idx_d = 1'b1;
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fastreadout_scan_ctrl.sv
// Directed bench for fastreadout_scan_ctrl (8x8 array, settle 3).
module tb_fastreadout_scan_ctrl;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int SET  = 3;
`ifdef FASTREADOUT_HEADER_EN
  localparam int HB = 2;
`else
  localparam int HB = 0;
`endif
  localparam int FB = ROWS * COLS + HB;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, cont_mode, abort, out_ready;
  logic [7:0] row_sel;
  logic [2:0] col_addr;
  logic       sample_en;
  logic [7:0] pix_in, out_data;
  logic       out_valid, busy, frame_done;

  int n_pass = 0, n_total = 0;
  int cyc = 0, fd_cnt = 0, fd_at = -1, se_cnt = 0;
  logic [7:0] bytes[$];
  int hs_cyc[$];
  logic [7:0] exp_fc = 8'd0;

  fastreadout_scan_ctrl #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SETTLE_CYC (SET),
    .DATA_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .cont_mode  (cont_mode),
    .abort      (abort),
    .row_sel    (row_sel),
    .col_addr   (col_addr),
    .sample_en  (sample_en),
    .pix_in     (pix_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Pixel source: value = row*16 + col, row taken from the one-hot select.
  always_comb begin
    int rix;
    rix = 0;
    for (int i = 0; i < ROWS; i++) if (row_sel[i]) rix = i;
    pix_in = 8'(rix * 16 + int'(col_addr));
  end

  // Byte/strobe logger on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && ena && !abort && out_valid && out_ready) begin
      bytes.push_back(out_data);
      hs_cyc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_at = bytes.size();
    end
    if (sample_en) se_cnt++;
  end

  function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] fc);
    int p;
    if (idx < HB) return (idx == 0) ? 8'hA5 : fc;
    p = idx - HB;
    return 8'((p / COLS) * 16 + (p % COLS));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    bytes.delete();
    hs_cyc.delete();
    fd_cnt = 0;
    fd_at  = -1;
    se_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    bit found;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (row_sel !== 8'h00) $display("FAIL rst_row_sel got %h want 00", row_sel); else n_pass++;
    n_total++; if (col_addr !== 3'd0) $display("FAIL rst_col_addr got %0d want 0", col_addr); else n_pass++;
    n_total++; if (sample_en !== 1'b0) $display("FAIL rst_sample_en got %b want 0", sample_en); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 8'h00) $display("FAIL rst_out_data got %h want 00", out_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done got %b want 0", frame_done); else n_pass++;
    clear_log();
    start = 1'b1;
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 1'b0;
      n++;
      if (sample_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_total++;
    if (!found || n != SET + 1 + 2 * HB)
      $display("FAIL start_latency got %0d (found=%0d) want %0d", n, found, SET + 1 + 2 * HB);
    else n_pass++;
    n_total++; if (row_sel !== 8'h01) $display("FAIL first_row_sel got %h want 01", row_sel); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_abort_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_full_frame();
    bit ok;
    int errs, bad;
    clear_log();
    cont_mode = 1'b0;
    out_ready = 1'b1;
    pulse_start();
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL ff_idle_timeout got busy want idle"); else n_pass++;
    n_total++; if (bytes.size() != FB) $display("FAIL ff_count got %0d want %0d", bytes.size(), FB); else n_pass++;
    errs = 0; bad = -1;
    for (int i = 0; i < bytes.size(); i++)
      if (bytes[i] !== exp_byte(i, exp_fc)) begin errs++; if (bad < 0) bad = i; end
    n_total++;
    if (errs != 0) $display("FAIL ff_stream %0d bad, first idx %0d got %h want %h", errs, bad, bytes[bad], exp_byte(bad, exp_fc));
    else n_pass++;
    n_total++; if (fd_cnt != 1) $display("FAIL ff_frame_done_count got %0d want 1", fd_cnt); else n_pass++;
    n_total++; if (fd_at != FB) $display("FAIL ff_frame_done_byte got %0d want %0d", fd_at, FB); else n_pass++;
    n_total++; if (row_sel !== 8'h00) $display("FAIL ff_row_sel_idle got %h want 00", row_sel); else n_pass++;
    n_total++; if (se_cnt != ROWS * COLS) $display("FAIL ff_sample_count got %0d want %0d", se_cnt, ROWS * COLS); else n_pass++;
    n_total++;
    if (hs_cyc.size() < HB + 2 || hs_cyc[HB + 1] - hs_cyc[HB] != 2)
      $display("FAIL ff_throughput got %0d cycles want 2", hs_cyc[HB + 1] - hs_cyc[HB]);
    else n_pass++;
    exp_fc++;
  endtask

  task automatic test_backpressure();
    bit ok, found;
    int errs, bad, se0;
    logic [7:0] d0;
    clear_log();
    out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && bytes.size() == HB + 2) begin found = 1'b1; break; end
      tick();
    end
    n_total++; if (!found) $display("FAIL bp_third_byte_timeout got none want valid"); else n_pass++;
    out_ready = 1'b0;
    d0 = out_data;
    se0 = se_cnt;
    n_total++; if (d0 !== 8'h02) $display("FAIL bp_third_byte got %h want 02", d0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b1 || out_data !== d0)
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, d0);
      else n_pass++;
    end
    n_total++; if (se_cnt != se0) $display("FAIL bp_extra_sample got %0d want %0d", se_cnt, se0); else n_pass++;
    out_ready = 1'b1;
    wait_idle(ok);
    n_total++; if (!ok || bytes.size() != FB) $display("FAIL bp_count got %0d want %0d", bytes.size(), FB); else n_pass++;
    errs = 0; bad = -1;
    for (int i = 0; i < bytes.size(); i++)
      if (bytes[i] !== exp_byte(i, exp_fc)) begin errs++; if (bad < 0) bad = i; end
    n_total++;
    if (errs != 0) $display("FAIL bp_stream %0d bad, first idx %0d got %h want %h", errs, bad, bytes[bad], exp_byte(bad, exp_fc));
    else n_pass++;
    n_total++; if (fd_cnt != 1) $display("FAIL bp_frame_done got %0d want 1", fd_cnt); else n_pass++;
    exp_fc++;
  endtask

  task automatic test_continuous();
    bit ok, found;
    int errs, bad;
    clear_log();
    out_ready = 1'b1;
    cont_mode = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (fd_cnt == 1) begin found = 1'b1; break; end
    end
    cont_mode = 1'b0;
    n_total++; if (!found) $display("FAIL cont_first_done_timeout got %0d want 1", fd_cnt); else n_pass++;
    n_total++; if (busy !== 1'b1 || row_sel !== 8'h01)
      $display("FAIL cont_restart got busy=%b row_sel=%h want busy=1 row_sel=01", busy, row_sel);
    else n_pass++;
    wait_idle(ok);
    n_total++; if (!ok || bytes.size() != 2 * FB) $display("FAIL cont_count got %0d want %0d", bytes.size(), 2 * FB); else n_pass++;
    errs = 0; bad = -1;
    for (int i = 0; i < bytes.size(); i++)
      if (bytes[i] !== exp_byte(i % FB, (i < FB) ? exp_fc : exp_fc + 8'd1)) begin errs++; if (bad < 0) bad = i; end
    n_total++;
    if (errs != 0) $display("FAIL cont_stream %0d bad, first idx %0d got %h", errs, bad, bytes[bad]);
    else n_pass++;
    n_total++; if (fd_cnt != 2) $display("FAIL cont_frame_done got %0d want 2", fd_cnt); else n_pass++;
    exp_fc = exp_fc + 8'd2;
  endtask

  task automatic test_abort();
    bit found;
    int se0;
    clear_log();
    out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && bytes.size() == HB + 29) begin found = 1'b1; break; end
      tick();
    end
    n_total++; if (!found || out_data !== 8'h35) $display("FAIL abort_target got %h want 35", out_data); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (row_sel !== 8'h00) $display("FAIL abort_row_sel got %h want 00", row_sel); else n_pass++;
    se0 = se_cnt;
    repeat (6) tick();
    n_total++; if (fd_cnt != 0) $display("FAIL abort_frame_done got %0d want 0", fd_cnt); else n_pass++;
    n_total++; if (se_cnt != se0 || bytes.size() != HB + 29)
      $display("FAIL abort_quiet got samples=%0d bytes=%0d want %0d %0d", se_cnt, bytes.size(), se0, HB + 29);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    clear_log();
    out_ready = 1'b0;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && se_cnt >= 1) begin found = 1'b1; break; end
      tick();
    end
    n_total++; if (!found) $display("FAIL rstmid_xfer_timeout got none want valid"); else n_pass++;
    tick();
    rst_n = 1'b0;
    tick();
    n_total++; if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rstmid_state got busy=%b valid=%b want 0 0", busy, out_valid);
    else n_pass++;
    n_total++; if (row_sel !== 8'h00 || out_data !== 8'h00)
      $display("FAIL rstmid_outputs got row_sel=%h data=%h want 00 00", row_sel, out_data);
    else n_pass++;
    n_total++; if (fd_cnt != 0) $display("FAIL rstmid_frame_done got %0d want 0", fd_cnt); else n_pass++;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    exp_fc = 8'd0;
  endtask

  task automatic test_ena_gating();
    bit ok, found;
    int errs, bad, se0;
    logic [2:0] ca;
    logic [7:0] d0;
    clear_log();
    out_ready = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (out_valid && bytes.size() == HB + 10) begin found = 1'b1; break; end
      tick();
    end
    n_total++; if (!found) $display("FAIL ena_target_timeout got none want valid"); else n_pass++;
    ena = 1'b0;
    ca = col_addr;
    d0 = out_data;
    se0 = se_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (col_addr !== ca || sample_en !== 1'b0 || out_valid !== 1'b1 || out_data !== d0)
        $display("FAIL ena_hold cycle %0d got col=%0d se=%b valid=%b data=%h want col=%0d se=0 valid=1 data=%h",
                 i, col_addr, sample_en, out_valid, out_data, ca, d0);
      else n_pass++;
    end
    n_total++; if (se_cnt != se0 || bytes.size() != HB + 10)
      $display("FAIL ena_frozen got samples=%0d bytes=%0d want %0d %0d", se_cnt, bytes.size(), se0, HB + 10);
    else n_pass++;
    ena = 1'b1;
    wait_idle(ok);
    n_total++; if (!ok || bytes.size() != FB) $display("FAIL ena_count got %0d want %0d", bytes.size(), FB); else n_pass++;
    errs = 0; bad = -1;
    for (int i = 0; i < bytes.size(); i++)
      if (bytes[i] !== exp_byte(i, exp_fc)) begin errs++; if (bad < 0) bad = i; end
    n_total++;
    if (errs != 0) $display("FAIL ena_stream %0d bad, first idx %0d got %h want %h", errs, bad, bytes[bad], exp_byte(bad, exp_fc));
    else n_pass++;
    n_total++; if (se_cnt != ROWS * COLS || fd_cnt != 1)
      $display("FAIL ena_totals got samples=%0d done=%0d want %0d 1", se_cnt, fd_cnt, ROWS * COLS);
    else n_pass++;
    exp_fc++;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_ena_gating();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fastreadout_scan_ctrl.md
Name: fastreadout_scan_ctrl

Overview:
Sequencer for the fast-readout pixel datapath inside the tt_um top. It walks a ROWS x COLS array row by row: asserts the one-hot row select, waits a settle time, then samples each column in turn. Each sample is pushed out through a valid/ready byte handshake that feeds the uo_out path. It supports single-frame and continuous-frame operation.

Parameters:
ROWS, 8, number of array rows (2..16)
COLS, 8, number of columns per row (2..16)
SETTLE_CYC, 3, clk cycles to wait after a row select change before the first sample (1..15)
DATA_W, 8, sample and output byte width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  design enable; when low, the FSM holds its state and all strobes are forced to 0
start  in  1  single-cycle pulse; begins a frame when in IDLE
cont_mode  in  1  1 = restart automatically after each frame; sampled at frame end
abort  in  1  single-cycle pulse; returns to IDLE at the next edge
row_sel  out  ROWS  one-hot row select; all zeros when idle
col_addr  out  $clog2(COLS)  column mux address
sample_en  out  1  one-cycle strobe; pix_in is captured on the same edge
pix_in  in  DATA_W  pixel value from the column mux
out_data  out  DATA_W  output byte
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the byte
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge) drives all outputs to 0: row_sel=0, col_addr=0, sample_en=0, out_valid=0, out_data=0, busy=0, frame_done=0. FSM goes to IDLE and counters clear. Reset mid-frame drops any pending byte with no handshake.
- FSM states and transitions:
  - IDLE: on start, go to SETTLE with row=0, col=0, and row_sel=1<<0.
  - SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: assert sample_en for one cycle and capture pix_in into out_data; set out_valid on the next cycle; go to XFER.
  - XFER: hold out_data/out_valid stable until out_valid&&out_ready. On that handshake:
    - if col<COLS-1: col++, go to SAMPLE.
    - else if row<ROWS-1: row++, col=0, update row_sel, go to SETTLE.
    - else: pulse frame_done. Then go to SETTLE with row=0 if cont_mode=1, else go to IDLE.
- Latency:
  - start to first sample_en = SETTLE_CYC+1 cycles.
  - sample_en to out_valid = 1 cycle.
  - handshake to next sample_en (same row) = 1 cycle.
- Column throughput with out_ready held at 1: one pixel every 2 cycles.
- out_valid deasserts in the cycle after a handshake. out_data must not change while out_valid=1 and out_ready=0.
- start while busy is ignored.
- abort has priority over every other event, including a handshake in the same cycle. It goes to IDLE, clears row_sel and out_valid, and does not pulse frame_done.
- ena=0: no state, counter or output-register updates; sample_en is forced low. A pending out_valid stays asserted, but a handshake in an ena=0 cycle is ignored.
- Counter wrap: col and row never exceed COLS-1 and ROWS-1; there is no modulo wrap outside the transitions listed above.
- A frame_done pulse coinciding with cont_mode restart still produces a single one-cycle pulse.

Optional Feature:
FASTREADOUT_HEADER_EN
- Defined: each frame begins with two header bytes in a HDR state between IDLE/frame-restart and the first SETTLE. The bytes are 0xA5 and then an 8-bit frame counter, each sent with the normal valid/ready handshake. The frame counter increments per completed frame, wraps at 255 to 0, and clears on reset. The frame_done timing is unchanged.
- Undefined: no HDR state; the first byte of a frame is pixel (0,0).

Decomposition:
- Package fastreadout_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, XFER, HDR);
  - the localparam HDR_SYNC = 8'hA5;
  - width helper functions.
- Sub-module fastreadout_addr_counter holds the row/col counters, the last_col/last_row flags and the one-hot row decode. It is instantiated once.
- The FSM, settle counter and output register stay in the top.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release. All outputs are 0 and busy=0. A start pulse gives exactly SETTLE_CYC+1 cycles to the first sample_en, with row_sel=8'h01.
- Full frame: ROWS=COLS=8, out_ready=1, pix_in=row*16+col. Expect 64 bytes in raster order, a single frame_done on byte 64, then IDLE with row_sel=0.
- Backpressure: out_ready low for 5 cycles on the 3rd byte. out_data/out_valid stay stable, no extra sample_en, and the byte stream stays identical to the unthrottled run.
- Continuous mode: cont_mode=1 for 2 frames. Expect 128 bytes, 2 frame_done pulses, and row_sel returning to 8'h01 after the SETTLE gap.
- Abort and reset mid-frame:
  - abort at row 3, col 5, in the same cycle as a handshake: IDLE next cycle, out_valid=0, no frame_done.
  - rst_n=0 mid-XFER gives the same result.
- ena gating: drop ena for 4 cycles mid-row. No counter advance and no sample_en. The stream resumes seamlessly. With FASTREADOUT_HEADER_EN defined, the stream begins 0xA5, 0x00 and the second frame's header is 0xA5, 0x01.
